// File: rtl/serial_word_collector_pkg.sv
// Shared types and constants for the serial word collector.
package serial_word_collector_pkg;

    localparam int unsigned StateWidth   = 1;
    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [StateWidth-1:0] {
        StIdle,
        StShift
    } state_e;

    // Bit counter runs 0..width-1.
    function automatic int unsigned count_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_word_collector.sv
// Deserialises an LSB-first bit stream into WIDTH-bit words with a one-deep output buffer
// and sticky framing/overrun status.
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_neg,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_flags
);

    localparam int unsigned CntW = count_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    // Only the upper WIDTH-1 bits are kept; bit 0 would shift out on the completing bit.
    logic [WIDTH-2:0]  sr_q, sr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_word_q, out_word_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic [WIDTH-1:0]  shifted;
    logic              complete;
    logic              frame_set;
    logic              overrun_set;

    assign shifted = {in_bit, sr_q};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        complete  = 1'b0;
        frame_set = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (in_first) begin
                        sr_d    = shifted[WIDTH-1:1];
                        cnt_d   = CntW'(1);
                        state_d = StShift;
                    end
                end
                StShift: begin
                    sr_d = shifted[WIDTH-1:1];
                    if (in_first && cnt_q != '0) begin
                        frame_set = 1'b1;
                        cnt_d     = CntW'(1);
                    end else if (cnt_q == LastCnt) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        overrun_set = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_word_d  = shifted;
                out_valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end
        // A new error in the same cycle as a clear takes precedence.
        frame_err_d = (frame_err_q && !clr_flags) || frame_set;
        overrun_d   = (overrun_q && !clr_flags) || overrun_set;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_neg   = out_word_q[WIDTH-1];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks each transfer.
module tb_serial_word_collector;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_b;
    logic         in_valid;
    logic         in_bit;
    logic         in_first;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_word;
    logic         out_neg;
    logic         frame_err;
    logic         overrun;
    logic         clr_flags;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb[$];

    serial_word_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_neg   (out_neg),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_flags (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_b && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got 0x%0h expected none at %0t", out_word, $time);
            end else begin
                logic [W-1:0] e;
                e = sb.pop_front();
                check("out_word", 32'(out_word), 32'(e));
                check("out_neg", 32'(out_neg), 32'(e[W-1]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic first);
        in_valid = 1'b1;
        in_bit   = b;
        in_first = first;
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit expect_out, input bit gaps);
        if (expect_out) sb.push_back(w);
        for (int i = 0; i < W; i++) begin
            send_bit(w[i], i == 0);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic check_flags(input string tag, input logic fe, input logic ov);
        check({tag, "_frame_err"}, 32'(frame_err), 32'(fe));
        check({tag, "_overrun"}, 32'(overrun), 32'(ov));
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    initial begin
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_word", 32'(out_word), 0);
        check("rst_out_neg", 32'(out_neg), 0);
        check_flags("rst", 1'b0, 1'b0);
        tick();
        rst_b = 1'b1;
        tick();

        // Single word, consumer ready: one transfer, no flags.
        send_word(8'h5A, 1, 0);
        repeat (2) tick();
        @(negedge clk);
        check("w5a_valid_dropped", 32'(out_valid), 0);
        check_flags("w5a", 1'b0, 1'b0);
        tick();

        // Held word stays stable while stalled.
        out_ready = 1'b0;
        send_word(8'hF3, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("f3_hold_valid", 32'(out_valid), 1);
            check("f3_hold_word", 32'(out_word), 32'h0000_00F3);
            check("f3_hold_neg", 32'(out_neg), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("f3_valid_dropped", 32'(out_valid), 0);
        tick();

        // Back-to-back words with no gap.
        send_word(8'h01, 1, 0);
        send_word(8'h80, 1, 0);
        repeat (2) tick();
        @(negedge clk);
        check_flags("b2b", 1'b0, 1'b0);
        tick();

        // Overrun: second word dropped while first is held.
        out_ready = 1'b0;
        send_word(8'h11, 1, 0);
        send_word(8'h22, 0, 0);
        @(negedge clk);
        check("ovr_word", 32'(out_word), 32'h0000_0011);
        check("ovr_valid", 32'(out_valid), 1);
        check_flags("ovr", 1'b0, 1'b1);
        tick();
        clear_flags();
        @(negedge clk);
        check_flags("ovr_clr", 1'b0, 1'b0);
        tick();
        out_ready = 1'b1;
        repeat (2) tick();

        // Framing error: restart after 3 bits.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_word(8'hC4, 1, 0);
        @(negedge clk);
        check_flags("frm", 1'b1, 1'b0);
        tick();
        clear_flags();
        @(negedge clk);
        check_flags("frm_clr", 1'b0, 1'b0);
        tick();

        // From reset, unframed bits are ignored; gaps inside a word are harmless.
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) send_bit(1'(i & 1), 1'b0);
        repeat (2) tick();
        @(negedge clk);
        check("unsync_no_valid", 32'(out_valid), 0);
        check_flags("unsync", 1'b0, 1'b0);
        tick();
        send_word(8'h3C, 1, 1);
        repeat (3) tick();

        // Reset mid-word clears buffered word and flags asynchronously.
        out_ready = 1'b0;
        send_word(8'hE7, 0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
        send_bit(1'b0, 1'b1);
        @(negedge clk);
        check("prerst_valid", 32'(out_valid), 1);
        check("prerst_neg", 32'(out_neg), 1);
        check_flags("prerst", 1'b1, 1'b0);
        #1 rst_b = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_word", 32'(out_word), 0);
        check("midrst_neg", 32'(out_neg), 0);
        check_flags("midrst", 1'b0, 1'b0);
        tick();
        rst_b     = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        send_word(8'h9B, 1, 0);
        repeat (3) tick();
        @(negedge clk);
        check_flags("post_rst", 1'b0, 1'b0);
        check("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
